regwrite_arbiter: RTL and testbench
===================================

// Module: regwrite_arbiter
// PURPOSE
//  Write-side front end of the integer register file. Merges the single-cycle ALU result
//  stream and the long-latency (load/mul/div) result stream onto the register file's single
//  write port (RegWrite/WriteReg/WriteData), buffering long-latency results in a small FIFO.
//  Keeps a pending-write scoreboard so decode stalls on registers still awaiting a long-latency result.
// PARAMETERS
//  XLEN   32  data width
//  AW     5   register address width (2**AW registers)
//  DEPTH  4   long-latency result FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset, synchronous, active-high
//  alu_valid  in   1        ALU result valid this cycle (no backpressure; always accepted)
//  alu_rd     in   AW       ALU destination register
//  alu_data   in   XLEN     ALU result
//  ll_valid   in   1        long-latency result valid
//  ll_ready   out  1        FIFO can accept (= !full); transfer on ll_valid && ll_ready
//  ll_rd      in   AW       long-latency destination register
//  ll_data    in   XLEN     long-latency result
//  iss_valid  in   1        decode issues a long-latency op this cycle
//  iss_rd     in   AW       its destination register
//  rf_we      out  1        register file write enable (drives RegWrite)
//  rf_waddr   out  AW       drives WriteReg
//  rf_wdata   out  XLEN     drives WriteData
//  busy       out  2**AW    bit r set = register r has an outstanding long-latency write
// BEHAVIOUR
//  - Reset: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, FIFO empty (ll_ready=1). Reset mid-drain
//    discards all buffered entries and clears busy; no write is issued on the reset edge.
//  - Outputs rf_* are registered. Per cycle, arbitration picks one source:
//      alu_valid                      -> load ALU result; FIFO head held
//      !alu_valid && FIFO non-empty   -> pop head, load it
//      else                           -> rf_we=0 (rf_waddr/rf_wdata hold)
//    ALU strictly higher priority; FIFO may starve under continuous ALU traffic (by design;
//    ll_ready backpressures upstream).
//  - Latency: ALU result at cycle N -> rf_we at N+1. LL result accepted at N -> earliest rf_we
//    at N+2 (written into FIFO at end of N, head arbitrated in N+1). No FIFO bypass.
//  - FIFO: in-order, DEPTH entries, pointers of log2(DEPTH)+1 bits, wrap naturally.
//    ll_ready = (count != DEPTH); push and pop in the same cycle allowed when not full
//    (count unchanged). Push when full never occurs (ready low).
//  - rd=0: results with rd=0 are accepted/popped normally but produce rf_we=0. busy[0] is
//    constant 0; iss_rd=0 ignored.
//  - Scoreboard: iss_valid sets busy[iss_rd] at the next edge. A register-1 flag rf_from_ll
//    marks an output write that came from the FIFO; busy[rf_waddr] clears on the edge where
//    rf_we && rf_from_ll (the same edge the register file commits), so decode sees busy=0 only
//    once the RF value is valid. Set and clear of the same register on one edge: set wins.
//  - Ordering: decode never issues a write to a busy rd (stall), so no WAW between sources;
//    block does not check this.
// STRUCTURE
//  - Shared package (core_pkg): XLEN, AW, reg-index typedef, result record {rd, data}.
//  - One sub-module: sync_fifo (DEPTH, width AW+XLEN) with push/pop/full/empty/head; arbiter,
//    output register and scoreboard stay in this module.
// TESTING
//  1. Reset: hold rst 2 cycles -> rf_we=0, busy=0, ll_ready=1; release, idle -> rf_we stays 0.
//  2. ALU alone: alu_valid rd=5 data=0x1234 at N -> rf_we=1, waddr=5, wdata=0x1234 at N+1 only.
//  3. Conflict: ALU rd=3 0xAA and LL rd=7 0xBB both at N -> rd3 written N+1, rd7 written N+2.
//  4. Full/drain: alu_valid held high, push 4 LL results rd=8..11 -> ll_ready=0 after 4th;
//     drop alu_valid -> rd 8,9,10,11 written on consecutive cycles, ll_ready returns to 1.
//  5. Scoreboard: iss rd=9 -> busy[9]=1 next cycle; LL rd=9 writeback -> busy[9]=0 on RF commit
//     edge; iss rd=9 on that same edge -> busy[9] stays 1.
//  6. x0 and reset: ALU rd=0 -> no rf_we; iss rd=0 -> busy[0]=0; rst with 3 FIFO entries ->
//     no further rf_we, busy=0.

Source files
------------

// File: rtl/regwrite_arbiter_pkg.sv
// Shared types for the register-file write front end: widths, register index and result record.
package regwrite_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NREG     = 1 << AW;
  localparam int LL_DEPTH = 4;

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xdata_t;
  typedef logic [NREG-1:0] reg_mask_t;

  typedef struct packed {
    reg_idx_t rd;
    xdata_t   data;
  } result_t;

  // One-hot register mask; x0 never maps to a bit so it can never become busy.
  function automatic reg_mask_t reg_mask(input reg_idx_t r);
    reg_mask_t m;
    m = '0;
    if (r != '0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Result streams in, register-file write port and scoreboard out.
interface regwrite_arbiter_if;
  import regwrite_arbiter_pkg::*;

  logic      alu_valid;
  reg_idx_t  alu_rd;
  xdata_t    alu_data;
  logic      ll_valid;
  logic      ll_ready;
  reg_idx_t  ll_rd;
  xdata_t    ll_data;
  logic      iss_valid;
  reg_idx_t  iss_rd;
  logic      rf_we;
  reg_idx_t  rf_waddr;
  xdata_t    rf_wdata;
  reg_mask_t busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ll_valid, ll_rd, ll_data,
    input  iss_valid, iss_rd,
    output ll_ready, rf_we, rf_waddr, rf_wdata, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ll_valid, ll_rd, ll_data,
    output iss_valid, iss_rd,
    input  ll_ready, rf_we, rf_waddr, rf_wdata, busy
  );

endinterface

// File: rtl/regwrite_arbiter_sync_fifo.sv
// In-order FIFO with extra pointer wrap bit for full/empty; storage is not reset.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0]  r_wptr;
  logic [PW:0]  r_rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[PW-1:0]] <= i_din;
  end

  assign o_head  = r_mem[r_rptr[PW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

endmodule

// File: rtl/regwrite_arbiter.sv
// Merges ALU and long-latency results onto the single RF write port (ALU first)
// and tracks registers still awaiting a long-latency write.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int DEPTH = LL_DEPTH
) (
  input logic               clk,
  input logic               rst,
  regwrite_arbiter_if.slave bus
);

  result_t   w_ll_res;
  result_t   w_head;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;
  reg_mask_t w_busy_set;
  reg_mask_t w_busy_clr;

  logic      r_we;
  reg_idx_t  r_waddr;
  xdata_t    r_wdata;
  logic      r_from_ll;
  reg_mask_t r_busy;

  assign w_ll_res.rd   = bus.ll_rd;
  assign w_ll_res.data = bus.ll_data;
  assign w_push        = bus.ll_valid && !w_full;
  assign w_pop         = !bus.alu_valid && !w_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(result_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_ll_res),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // x0 results still load the output register but never assert the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_from_ll <= 1'b0;
    end else if (bus.alu_valid) begin
      r_we      <= (bus.alu_rd != '0);
      r_waddr   <= bus.alu_rd;
      r_wdata   <= bus.alu_data;
      r_from_ll <= 1'b0;
    end else if (w_pop) begin
      r_we      <= (w_head.rd != '0);
      r_waddr   <= w_head.rd;
      r_wdata   <= w_head.data;
      r_from_ll <= 1'b1;
    end else begin
      r_we      <= 1'b0;
      r_from_ll <= 1'b0;
    end
  end

  // Clear on the RF commit edge of a FIFO-sourced write; a same-edge issue re-sets the bit.
  assign w_busy_clr = (r_we && r_from_ll) ? reg_mask(r_waddr) : '0;
  assign w_busy_set = bus.iss_valid ? reg_mask(bus.iss_rd) : '0;

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
  end

  assign bus.ll_ready = !w_full;
  assign bus.rf_we    = r_we;
  assign bus.rf_waddr = r_waddr;
  assign bus.rf_wdata = r_wdata;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_regwrite_arbiter;
  import regwrite_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regwrite_arbiter_if bus ();

  regwrite_arbiter #(.DEPTH(LL_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending LL results as a queue, busy as a plain bit set,
  // and the write visible on the port during the current cycle.
  result_t   m_q[$];
  result_t   m_e;
  bit        m_ok  = 0;
  bit        m_acc;
  logic      m_we;
  reg_idx_t  m_waddr;
  xdata_t    m_wdata;
  bit        m_ll;
  reg_mask_t m_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_we = 0; m_waddr = 0; m_wdata = 0; m_ll = 0; m_busy = 0;
      m_ok = 1;
    end else if (m_ok) begin
      m_acc = bus.ll_valid && (m_q.size() < LL_DEPTH);
      if (m_we && m_ll) m_busy[m_waddr] = 1'b0;
      if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
      if (bus.alu_valid) begin
        m_we = (bus.alu_rd != 0); m_waddr = bus.alu_rd; m_wdata = bus.alu_data; m_ll = 0;
      end else if (m_q.size() > 0) begin
        m_e = m_q.pop_front();
        m_we = (m_e.rd != 0); m_waddr = m_e.rd; m_wdata = m_e.data; m_ll = 1;
      end else begin
        m_we = 0; m_ll = 0;
      end
      if (m_acc) begin
        m_e.rd = bus.ll_rd; m_e.data = bus.ll_data;
        m_q.push_back(m_e);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("mdl_rf_we", bus.rf_we, m_we);
      if (m_we) begin
        chk("mdl_rf_waddr", bus.rf_waddr, m_waddr);
        chk("mdl_rf_wdata", bus.rf_wdata, m_wdata);
      end
      chk("mdl_busy", bus.busy, m_busy);
      chk("mdl_ll_ready", bus.ll_ready, m_q.size() != LL_DEPTH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.ll_valid = 0;  bus.ll_rd = 0;  bus.ll_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0;

    // 1. reset
    tick(); tick();
    chk("rst_we", bus.rf_we, 0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.ll_ready, 1);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_we", bus.rf_we, 0);
    end

    // 2. ALU alone
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'h1234;
    tick();
    bus.alu_valid = 0;
    chk("alu_we", bus.rf_we, 1);
    chk("alu_waddr", bus.rf_waddr, 5);
    chk("alu_wdata", bus.rf_wdata, 32'h1234);
    tick();
    chk("alu_we_drop", bus.rf_we, 0);

    // 3. same-cycle conflict
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'hAA;
    bus.ll_valid = 1;  bus.ll_rd = 7;  bus.ll_data = 32'hBB;
    tick();
    bus.alu_valid = 0; bus.ll_valid = 0;
    chk("cf_alu_waddr", bus.rf_waddr, 3);
    chk("cf_alu_wdata", bus.rf_wdata, 32'hAA);
    tick();
    chk("cf_ll_we", bus.rf_we, 1);
    chk("cf_ll_waddr", bus.rf_waddr, 7);
    chk("cf_ll_wdata", bus.rf_wdata, 32'hBB);
    tick();
    chk("cf_idle", bus.rf_we, 0);

    // 4. fill under ALU pressure, then drain
    bus.alu_valid = 1; bus.alu_rd = 1;
    for (int i = 0; i < 4; i++) begin
      bus.alu_data = 32'h100 + i;
      bus.ll_valid = 1; bus.ll_rd = reg_idx_t'(8 + i); bus.ll_data = 32'h800 + i;
      tick();
      chk("fill_ready", bus.ll_ready, (i == 3) ? 0 : 1);
      chk("fill_alu_waddr", bus.rf_waddr, 1);
    end
    bus.ll_valid = 0;
    bus.alu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_we", bus.rf_we, 1);
      chk("drain_waddr", bus.rf_waddr, 8 + i);
      chk("drain_wdata", bus.rf_wdata, 32'h800 + i);
      chk("drain_ready", bus.ll_ready, 1);
    end
    tick();
    chk("drain_idle", bus.rf_we, 0);

    // 5. scoreboard: plain clear, then set winning over clear
    bus.iss_valid = 1; bus.iss_rd = 9;
    tick();
    bus.iss_valid = 0;
    chk("sb_set", bus.busy[9], 1);
    bus.ll_valid = 1; bus.ll_rd = 9; bus.ll_data = 32'h99;
    tick();
    bus.ll_valid = 0;
    tick();
    chk("sb_commit_waddr", bus.rf_waddr, 9);
    chk("sb_busy_during_we", bus.busy[9], 1);
    tick();
    chk("sb_clear", bus.busy[9], 0);

    bus.iss_valid = 1; bus.iss_rd = 9;
    tick();
    bus.iss_valid = 0;
    bus.ll_valid = 1; bus.ll_rd = 9; bus.ll_data = 32'h9A;
    tick();
    bus.ll_valid = 0;
    tick();
    chk("sb2_we", bus.rf_we, 1);
    bus.iss_valid = 1; bus.iss_rd = 9;
    tick();
    bus.iss_valid = 0;
    chk("sb_set_wins", bus.busy[9], 1);
    bus.ll_valid = 1; bus.ll_rd = 9; bus.ll_data = 32'h9B;
    tick();
    bus.ll_valid = 0;
    tick(); tick();
    chk("sb_final_clear", bus.busy, 0);

    // 6. x0 handling and reset mid-drain
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hDEAD;
    tick();
    bus.alu_valid = 0;
    chk("x0_alu_we", bus.rf_we, 0);
    bus.iss_valid = 1; bus.iss_rd = 0;
    tick();
    bus.iss_valid = 0;
    chk("x0_busy", bus.busy, 0);
    bus.ll_valid = 1; bus.ll_rd = 0; bus.ll_data = 32'h5;
    tick();
    bus.ll_valid = 0;
    tick();
    chk("x0_ll_we", bus.rf_we, 0);

    bus.iss_valid = 1; bus.iss_rd = 12;
    bus.alu_valid = 1; bus.alu_rd = 2; bus.alu_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      bus.ll_valid = 1; bus.ll_rd = reg_idx_t'(12 + i); bus.ll_data = 32'hC00 + i;
      tick();
      bus.iss_valid = 0;
    end
    bus.ll_valid = 0;
    chk("pre_rst_busy12", bus.busy[12], 1);
    bus.alu_valid = 0;
    rst = 1;
    tick();
    chk("mid_rst_we", bus.rf_we, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.ll_ready, 1);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_we", bus.rf_we, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
